// File: rtl/stc0_ingress_framer.sv
// Frame-checking ingress buffer: hunts for a sync byte, parses length/payload/checksum,
// buffers the payload speculatively and releases it downstream only once the checksum passes.
module stc0_ingress_framer #(
    parameter int          DEPTH   = 32,
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic        ClkIngress,
    input  logic        ARstb,
    input  logic        IValid,
    input  logic [7:0]  ID,
    output logic        OValid,
    output logic [7:0]  OD,
    output logic        OLast,
    input  logic        OReady,
    output logic [15:0] FrameOkCnt,
    output logic [15:0] FrameErrCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      sum_q, sum_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_commit_q, wr_commit_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovalid_q, ovalid_d;
    logic [7:0]      od_q, od_d;
    logic            olast_q, olast_d;
    logic [15:0]     ok_cnt_q, ok_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic [8:0]      mem_q [DEPTH];
    logic            wr_en_s;
    logic [8:0]      wr_data_s;
    logic            full_s;
    logic            rd_fire_s;
    logic            ok_inc_s;
    logic            err_inc_s;
    logic [8:0]      rd_entry_s;

    // Frame parser, pointer management and lookahead of the registered output stage
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        wr_en_s     = 1'b0;
        wr_data_s   = {rem_q == 8'd1, ID};
        ok_inc_s    = 1'b0;
        err_inc_s   = 1'b0;
        full_s      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        rd_fire_s   = ovalid_q && OReady;

        if (IValid) begin
            case (state_q)
                ST_HUNT: begin
                    if (ID == SYNC) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    if ((ID == 8'd0) || (ID > 8'(MAX_LEN))) begin
                        err_inc_s = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        rem_d   = ID;
                        sum_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (full_s) begin
                        wr_ptr_d  = wr_commit_q;
                        err_inc_s = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        sum_d    = sum_q + ID;
                        rem_d    = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_CSUM: begin
                    if (ID == sum_q) begin
                        wr_commit_d = wr_ptr_q;
                        ok_inc_s    = 1'b1;
                    end else begin
                        wr_ptr_d  = wr_commit_q;
                        err_inc_s = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (ok_inc_s && (ok_cnt_q != 16'hFFFF)) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end else begin
            ok_cnt_d = ok_cnt_q;
        end
        if (err_inc_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        // Entries below the next commit point were written on earlier edges, so the
        // old memory contents are the right source for the next-cycle output.
        rd_ptr_d   = rd_ptr_q + (rd_fire_s ? PW'(1) : PW'(0));
        rd_entry_s = mem_q[rd_ptr_d[AW-1:0]];
        ovalid_d   = (rd_ptr_d != wr_commit_d);
        if (ovalid_d) begin
            od_d    = rd_entry_s[7:0];
            olast_d = rd_entry_s[8];
        end else begin
            od_d    = 8'd0;
            olast_d = 1'b0;
        end
    end

    // Payload storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge ClkIngress) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_s;
        end
    end

    // Parser state, pointers, counters and registered output stage
    always_ff @(posedge ClkIngress or negedge ARstb) begin
        if (!ARstb) begin
            state_q     <= ST_HUNT;
            rem_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            ovalid_q    <= 1'b0;
            od_q        <= 8'd0;
            olast_q     <= 1'b0;
            ok_cnt_q    <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            ovalid_q    <= ovalid_d;
            od_q        <= od_d;
            olast_q     <= olast_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign OValid      = ovalid_q;
    assign OD          = od_q;
    assign OLast       = olast_q;
    assign FrameOkCnt  = ok_cnt_q;
    assign FrameErrCnt = err_cnt_q;

endmodule

// File: tb/tb_stc0_ingress_framer.sv
// Scoreboard bench for stc0_ingress_framer: a frame-level reference model predicts the
// committed byte stream and counters; a monitor checks every output handshake.
module tb_stc0_ingress_framer;

    logic        clk;
    logic        rst_n;
    logic        ivalid;
    logic [7:0]  id;
    logic        ovalid;
    logic [7:0]  od;
    logic        olast;
    logic        oready;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    stc0_ingress_framer dut (
        .ClkIngress (clk),
        .ARstb      (rst_n),
        .IValid     (ivalid),
        .ID         (id),
        .OValid     (ovalid),
        .OD         (od),
        .OLast      (olast),
        .OReady     (oready),
        .FrameOkCnt (ok_cnt),
        .FrameErrCnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_q[$];
    logic [8:0] pend_q[$];
    int         m_mode;
    int         m_rem;
    logic [7:0] m_sum;
    int         m_committed;
    int         m_reads;
    int         m_ok;
    int         m_err;
    int         rdy_mode;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        m_mode = 0; m_rem = 0; m_sum = 8'd0;
        m_committed = 0; m_reads = 0; m_ok = 0; m_err = 0;
    endtask

    task automatic bump_err();
        if (m_err < 65535) m_err++;
    endtask

    // Frame rules: 0 hunting, 1 expecting length, 2 collecting payload, 3 expecting checksum
    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            0: if (b == 8'hA5) m_mode = 1;
            1: begin
                if (b == 8'd0 || b > 8'd16) begin
                    bump_err(); m_mode = 0;
                end else begin
                    m_rem = b; m_sum = 8'd0; pend_q.delete(); m_mode = 2;
                end
            end
            2: begin
                if (m_committed - m_reads + pend_q.size() == 32) begin
                    pend_q.delete(); bump_err(); m_mode = 0;
                end else begin
                    pend_q.push_back({m_rem == 1, b});
                    m_sum = m_sum + b;
                    m_rem--;
                    if (m_rem == 0) m_mode = 3;
                end
            end
            default: begin
                if (b == m_sum) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    m_committed += pend_q.size();
                    if (m_ok < 65535) m_ok++;
                end else begin
                    bump_err();
                end
                pend_q.delete();
                m_mode = 0;
            end
        endcase
    endtask

    // Output monitor: every accepted byte must be the next one the model committed
    always @(negedge clk) begin
        if (rst_n && ovalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_ovalid", 1, 0);
            end else if (oready) begin
                check("od", od, exp_q[0][7:0]);
                check("olast", olast, exp_q[0][8]);
                void'(exp_q.pop_front());
                m_reads++;
            end
        end
    end

    task automatic cycle(input logic v, input logic [7:0] b);
        @(posedge clk); #1;
        ivalid = v;
        id     = b;
        case (rdy_mode)
            0:       oready = 1'b0;
            1:       oready = 1'b1;
            default: oready = ($urandom_range(0, 3) != 0);
        endcase
        if (v) model_byte(b);
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        int g;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (g) cycle(1'b0, 8'd0);
        cycle(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) send(bytes[i], max_gap);
        cycle(1'b0, 8'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'd0);
    endtask

    task automatic check_counters(input string tag);
        idle(2);
        check({tag, "_ok_cnt"}, ok_cnt, m_ok);
        check({tag, "_err_cnt"}, err_cnt, m_err);
    endtask

    task automatic drain();
        int budget;
        rdy_mode = 1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            cycle(1'b0, 8'd0);
            budget++;
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(2);
        check("drained_ovalid", ovalid, 0);
    endtask

    task automatic make_frame(input int len, input bit bad_sum, output logic [7:0] f[$]);
        logic [7:0] s;
        f.delete();
        s = 8'd0;
        f.push_back(8'hA5);
        f.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            logic [7:0] p;
            p = 8'($urandom_range(0, 255));
            f.push_back(p);
            s = s + p;
        end
        f.push_back(bad_sum ? s ^ 8'(1 << $urandom_range(0, 7)) : s);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] t1[$];
        int base_err;

        t1 = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        ivalid = 1'b0; id = 8'd0; oready = 1'b0; rdy_mode = 1;
        model_reset();
        rst_n = 1'b0;
        #23;
        check("rst_ovalid", ovalid, 0);
        check("rst_od", od, 0);
        check("rst_olast", olast, 0);
        check("rst_ok", ok_cnt, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        idle(2);

        // Good frame and first-word-fall-through latency
        foreach (t1[i]) cycle(1'b1, t1[i]);
        cycle(1'b0, 8'd0);
        @(negedge clk);
        check("t1_ovalid_latency", ovalid, 1);
        check("t1_first_od", od, 8'h11);
        @(negedge clk);
        check("t1_second_valid", ovalid, 1);
        @(negedge clk);
        check("t1_third_last", {ovalid, olast}, 2'b11);
        @(negedge clk);
        check("t1_after_frame", ovalid, 0);
        check_counters("t1");
        check("t1_ok_const", ok_cnt, 1);

        // Bad checksum, then a one-byte frame
        send_frame('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31}, 0);
        check_counters("t2_bad");
        check("t2_err_const", err_cnt, 1);
        send_frame('{8'hA5, 8'h01, 8'h7E, 8'h7E}, 0);
        check_counters("t2_good");

        // Illegal lengths
        send_frame('{8'hA5, 8'h00}, 0);
        send_frame('{8'hA5, 8'h11}, 0);
        check_counters("t3_len");
        send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03}, 0);
        check_counters("t3_good");
        drain();

        // Overflow with downstream stalled
        rdy_mode = 0;
        base_err = m_err;
        for (int k = 0; k < 2; k++) begin
            make_frame(16, 1'b0, fr);
            send_frame(fr, 0);
        end
        fr.delete();
        fr.push_back(8'hA5); fr.push_back(8'h10);
        for (int i = 0; i < 16; i++) fr.push_back(8'h01);
        fr.push_back(8'h10);
        send_frame(fr, 0);
        check_counters("t4_full");
        check("t4_err_delta", err_cnt - base_err, 1);
        check("t4_backlog", exp_q.size(), 32);
        check("t4_stall_hold", {ovalid, od}, {1'b1, exp_q[0][7:0]});
        drain();

        // Test-1 frame with random ingress gaps and output stalls
        for (int k = 0; k < 12; k++) begin
            rdy_mode = 2;
            send_frame(t1, 5);
        end
        drain();
        check_counters("t5");

        // Random mix of good, bad-checksum, bad-length frames and line noise
        for (int k = 0; k < 120; k++) begin
            int kind;
            rdy_mode = 2;
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                make_frame($urandom_range(1, 16), 1'b0, fr);
            end else if (kind < 8) begin
                make_frame($urandom_range(1, 16), 1'b1, fr);
            end else if (kind == 8) begin
                fr = '{8'hA5, 8'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255))};
            end else begin
                fr.delete();
                repeat ($urandom_range(1, 6)) fr.push_back(8'($urandom_range(0, 255)));
            end
            send_frame(fr, 2);
        end
        drain();
        check_counters("rand");

        // Asynchronous reset mid-frame, then normal operation
        rdy_mode = 1;
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h03);
        cycle(1'b1, 8'h11);
        @(posedge clk); #1;
        ivalid = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check("t6_ovalid", ovalid, 0);
        check("t6_od", od, 0);
        check("t6_olast", olast, 0);
        check("t6_ok", ok_cnt, 0);
        check("t6_err", err_cnt, 0);
        #2;
        rst_n = 1'b1;
        idle(2);
        send_frame(t1, 0);
        drain();
        check_counters("t6");
        check("t6_ok_const", ok_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
